// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings,
// default datapath width and the load misalignment rule.
package wb_stage_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      F3_LB  = 3'b000,
      F3_LH  = 3'b001,
      F3_LW  = 3'b010,
      F3_LBU = 3'b100,
      F3_LHU = 3'b101
   } load_funct3_e;

   // Unknown encodings behave as LW, including the alignment check.
   function automatic logic load_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      load_funct3_e f3;
      f3 = load_funct3_e'(funct3);
      case (f3)
         F3_LB, F3_LBU: return 1'b0;
         F3_LH, F3_LHU: return offset[0];
         default:       return (offset != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load data extraction: byte/halfword select and sign/zero
// extension from an aligned memory word, plus the misalignment flag.
module load_extend
   import wb_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [2:0]            funct3,
   input  logic [1:0]            offset,
   input  logic [DATA_WIDTH-1:0] data,
   output logic [DATA_WIDTH-1:0] ext_data,
   output logic                  misalign
);

   logic [7:0]   byte_s;
   logic [15:0]  half_s;
   load_funct3_e f3_s;

   // Halfword select ignores offset[0], which realigns misaligned halfwords.
   always_comb begin
      byte_s   = data[{offset, 3'b000} +: 8];
      half_s   = data[{offset[1], 4'b0000} +: 16];
      f3_s     = load_funct3_e'(funct3);
      misalign = load_misaligned(funct3, offset);
      case (f3_s)
         F3_LB:   ext_data = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
         F3_LBU:  ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_s};
         F3_LH:   ext_data = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
         F3_LHU:  ext_data = {{(DATA_WIDTH-16){1'b0}}, half_s};
         default: ext_data = data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates load/ALU results onto the single regfile
// write port and keeps the busy scoreboard used by decode for RAW/WAW stalls.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  issue_valid_i,
   input  logic [4:0]            issue_rs1_i,
   input  logic [4:0]            issue_rs2_i,
   input  logic [4:0]            issue_rd_i,
   output logic                  stall_o,
   input  logic                  alu_valid_i,
   output logic                  alu_ready_o,
   input  logic [4:0]            alu_rd_i,
   input  logic [DATA_WIDTH-1:0] alu_data_i,
   input  logic                  lsu_valid_i,
   input  logic [4:0]            lsu_rd_i,
   input  logic [2:0]            lsu_funct3_i,
   input  logic [1:0]            lsu_offset_i,
   input  logic [DATA_WIDTH-1:0] lsu_data_i,
   output logic [4:0]            w_addr_o,
   output logic [DATA_WIDTH-1:0] din_o,
   output logic                  misalign_o
);

   logic [31:1]           busy_r;
   logic [31:1]           busy_nxt_s;
   logic [4:0]            w_addr_r;
   logic [DATA_WIDTH-1:0] din_r;
   logic                  misalign_r;

   logic [DATA_WIDTH-1:0] ld_data_s;
   logic                  ld_misalign_s;
   logic                  beat_valid_s;
   logic [4:0]            beat_rd_s;
   logic [DATA_WIDTH-1:0] beat_data_s;
   logic                  issue_fire_s;

   // x0 has no scoreboard bit and is never busy.
   function automatic logic busy_of(input logic [31:1] vec, input logic [4:0] idx);
      if (idx == 5'd0) begin
         return 1'b0;
      end else begin
         return vec[idx];
      end
   endfunction

   load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .funct3   (lsu_funct3_i),
      .offset   (lsu_offset_i),
      .data     (lsu_data_i),
      .ext_data (ld_data_s),
      .misalign (ld_misalign_s)
   );

   assign alu_ready_o = ~lsu_valid_i;

   // Hazard detection against in-flight writes.
   always_comb begin
      stall_o = issue_valid_i & (busy_of(busy_r, issue_rs1_i) |
                                 busy_of(busy_r, issue_rs2_i) |
                                 busy_of(busy_r, issue_rd_i));
      issue_fire_s = issue_valid_i & ~stall_o & (issue_rd_i != 5'd0);
   end

   // Load beats cannot be stalled, so they always win the write port.
   always_comb begin
      beat_valid_s = 1'b0;
      beat_rd_s    = 5'd0;
      beat_data_s  = '0;
      if (lsu_valid_i) begin
         beat_valid_s = 1'b1;
         beat_rd_s    = lsu_rd_i;
         beat_data_s  = ld_data_s;
      end else if (alu_valid_i) begin
         beat_valid_s = 1'b1;
         beat_rd_s    = alu_rd_i;
         beat_data_s  = alu_data_i;
      end else begin
         beat_valid_s = 1'b0;
      end
   end

   // Clear the bit being committed this edge, then apply a new issue so set wins.
   always_comb begin
      busy_nxt_s = busy_r;
      if (w_addr_r != 5'd0) begin
         busy_nxt_s[w_addr_r] = 1'b0;
      end else begin
         busy_nxt_s = busy_r;
      end
      if (issue_fire_s) begin
         busy_nxt_s[issue_rd_i] = 1'b1;
      end else begin
         busy_nxt_s = busy_nxt_s;
      end
   end

   // Output registers and scoreboard state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy_r     <= '0;
         w_addr_r   <= 5'd0;
         din_r      <= '0;
         misalign_r <= 1'b0;
      end else begin
         busy_r     <= busy_nxt_s;
         w_addr_r   <= beat_valid_s ? beat_rd_s : 5'd0;
         misalign_r <= lsu_valid_i & ld_misalign_s;
         if (beat_valid_s) begin
            din_r <= beat_data_s;
         end
      end
   end

   assign w_addr_o   = w_addr_r;
   assign din_o      = din_r;
   assign misalign_o = misalign_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// traffic compared against a behavioural scoreboard/regfile model.
`timescale 1ns/1ps
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        issue_valid;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        stall;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_offset;
   logic [31:0] lsu_data;
   logic [4:0]  w_addr;
   logic [31:0] din;
   logic        misalign;

   wb_stage dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .issue_valid_i(issue_valid), .issue_rs1_i(issue_rs1), .issue_rs2_i(issue_rs2),
      .issue_rd_i(issue_rd), .stall_o(stall),
      .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
      .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_funct3_i(lsu_funct3),
      .lsu_offset_i(lsu_offset), .lsu_data_i(lsu_data),
      .w_addr_o(w_addr), .din_o(din), .misalign_o(misalign)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: busy flags, the write presented this cycle, and
   // two register files (one fed by the model, one fed by the DUT outputs).
   bit          mb [32];
   logic [4:0]  e_waddr;
   logic [31:0] e_din;
   logic        e_mis;
   logic [31:0] m_rf [32];
   logic [31:0] t_rf [32];
   logic        last_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
      logic [31:0] v;
      case (f3)
         3'd0: begin v = (d >> (8 * off)) & 32'hFF;           if (v >= 32'd128)   v = v | 32'hFFFF_FF00; end
         3'd4: v = (d >> (8 * off)) & 32'hFF;
         3'd1: begin v = (d >> (16 * (off / 2))) & 32'hFFFF;  if (v >= 32'd32768) v = v | 32'hFFFF_0000; end
         3'd5: v = (d >> (16 * (off / 2))) & 32'hFFFF;
         default: v = d;
      endcase
      return v;
   endfunction

   function automatic logic ref_mis(input logic [2:0] f3, input logic [1:0] off);
      if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
      if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) == 1;
      return off != 2'd0;
   endfunction

   task automatic model_reset();
      foreach (mb[k]) mb[k] = 1'b0;
      e_waddr = 5'd0;
      e_din   = 32'd0;
      e_mis   = 1'b0;
   endtask

   // One clock cycle: drive, check combinational outputs, advance model, check registers.
   task automatic cycle(input bit iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [2:0] lf3,
                        input logic [1:0] loff, input logic [31:0] ld);
      bit          exp_stall;
      logic [4:0]  wa_now;
      logic [31:0] din_now;
      @(negedge clk);
      issue_valid = iv; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_funct3 = lf3; lsu_offset = loff; lsu_data = ld;
      #1;
      exp_stall = iv && (mb[rs1] || mb[rs2] || mb[rd]);
      last_stall = stall;
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("alu_ready", {31'd0, alu_ready}, {31'd0, !lv});
      if (iv && !exp_stall) begin
         check("rs1_value", t_rf[rs1], m_rf[rs1]);
         check("rs2_value", t_rf[rs2], m_rf[rs2]);
      end
      wa_now  = w_addr;
      din_now = din;
      @(posedge clk);
      if (wa_now != 5'd0) t_rf[wa_now] = din_now;
      if (e_waddr != 5'd0) begin
         m_rf[e_waddr] = e_din;
         mb[e_waddr]   = 1'b0;
      end
      if (iv && !exp_stall && rd != 5'd0) mb[rd] = 1'b1;
      if (lv) begin
         e_waddr = lrd; e_din = ref_load(lf3, loff, ld); e_mis = ref_mis(lf3, loff);
      end else if (av) begin
         e_waddr = ard; e_din = ad; e_mis = 1'b0;
      end else begin
         e_waddr = 5'd0; e_mis = 1'b0;
      end
      #1;
      check("w_addr", {27'd0, w_addr}, {27'd0, e_waddr});
      if (e_waddr != 5'd0) check("din", din, e_din);
      check("misalign", {31'd0, misalign}, {31'd0, e_mis});
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);
   endtask

   task automatic alu(input logic [4:0] rd, input logic [31:0] d);
      cycle(0, 0, 0, 0, 1, rd, d, 0, 0, 3'd0, 2'd0, 32'd0);
   endtask

   task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
      cycle(0, 0, 0, 0, 0, 0, 32'd0, 1, rd, f3, off, d);
   endtask

   function automatic logic [4:0] pick_reg();
      if ($urandom_range(0, 4) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   logic [2:0]  f3_tab [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   bit          r_iv, r_lv, a_v;
   logic [4:0]  r_rs1, r_rs2, r_rd, a_rd, r_lrd;
   logic [31:0] a_d, r_ld;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;

   initial begin
      foreach (m_rf[k]) begin m_rf[k] = 32'd0; t_rf[k] = 32'd0; end
      model_reset();
      issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
      lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_funct3 = 3'd0; lsu_offset = 2'd0; lsu_data = 32'd0;

      // Reset state; stall reflects only the inputs while in reset.
      repeat (2) @(negedge clk);
      issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs2 = 5'd6; issue_rd = 5'd7;
      #1;
      check("rst_w_addr", {27'd0, w_addr}, 32'd0);
      check("rst_din", din, 32'd0);
      check("rst_misalign", {31'd0, misalign}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      issue_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // ALU beat to x5 appears for one cycle only.
      alu(5'd5, 32'h1234);
      check("alu_w_addr", {27'd0, w_addr}, 32'd5);
      check("alu_din", din, 32'h1234);
      idle();
      check("alu_w_addr_drop", {27'd0, w_addr}, 32'd0);
      cycle(1, 5, 0, 0, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);

      // RAW on x3: stalled until the cycle after writeback.
      cycle(1, 0, 0, 3, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);
      cycle(1, 3, 0, 0, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);
      check("raw_stall_wait", {31'd0, last_stall}, 32'd1);
      cycle(1, 3, 0, 0, 1, 3, 32'hCAFE, 0, 0, 3'd0, 2'd0, 32'd0);
      cycle(1, 3, 0, 0, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);
      check("raw_stall_wb", {31'd0, last_stall}, 32'd1);
      cycle(1, 3, 0, 0, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);
      check("raw_release", {31'd0, last_stall}, 32'd0);
      check("raw_x3_value", t_rf[3], 32'hCAFE);

      // Load and ALU together: load first, held ALU beat next.
      cycle(0, 0, 0, 0, 1, 6, 32'h66, 1, 4, 3'd2, 2'd0, 32'h44);
      check("arb_load_first", {27'd0, w_addr}, 32'd4);
      alu(5'd6, 32'h66);
      check("arb_alu_second", {27'd0, w_addr}, 32'd6);

      // Load extraction.
      load(5'd8, 3'd0, 2'd2, 32'h0080_0000);
      check("lb_sext", din, 32'hFFFF_FF80);
      load(5'd8, 3'd4, 2'd2, 32'h0080_0000);
      check("lbu_zext", din, 32'h0000_0080);
      load(5'd9, 3'd5, 2'd2, 32'hBEEF_0000);
      check("lhu_hi", din, 32'h0000_BEEF);
      load(5'd10, 3'd2, 2'd1, 32'hDEAD_BEEF);
      check("lw_mis_pulse", {31'd0, misalign}, 32'd1);
      check("lw_mis_data", din, 32'hDEAD_BEEF);
      idle();
      check("lw_mis_drop", {31'd0, misalign}, 32'd0);

      // Writeback of x7 and issue of rd=7 on one edge: set wins.
      alu(5'd7, 32'h77);
      cycle(1, 0, 0, 7, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);
      cycle(1, 7, 0, 0, 0, 0, 32'd0, 0, 0, 3'd0, 2'd0, 32'd0);
      check("setwins_busy7", {31'd0, last_stall}, 32'd1);
      alu(5'd7, 32'h78);
      idle();

      // ALU beat to x0 is discarded.
      alu(5'd0, 32'h99);
      check("rd0_no_write", {27'd0, w_addr}, 32'd0);
      idle();

      // Randomized traffic with a mid-run asynchronous reset.
      a_v = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         r_iv  = ($urandom_range(0, 2) != 0);
         r_rs1 = pick_reg(); r_rs2 = pick_reg(); r_rd = pick_reg();
         if (!a_v) begin
            a_v  = ($urandom_range(0, 1) == 1);
            a_rd = pick_reg();
            a_d  = $urandom;
         end
         r_lv  = ($urandom_range(0, 3) == 0);
         r_lrd = pick_reg();
         r_f3  = f3_tab[$urandom_range(0, 4)];
         r_off = 2'($urandom_range(0, 3));
         r_ld  = $urandom;
         cycle(r_iv, r_rs1, r_rs2, r_rd, a_v, a_rd, a_d, r_lv, r_lrd, r_f3, r_off, r_ld);
         if (a_v && !r_lv) a_v = 1'b0;
         if (i == 1000) begin
            @(negedge clk);
            issue_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
            #2 rst_n = 1'b0;
            issue_valid = 1'b1; issue_rs1 = 5'd1; issue_rs2 = 5'd2; issue_rd = 5'd3;
            #1;
            check("midrst_w_addr", {27'd0, w_addr}, 32'd0);
            check("midrst_din", din, 32'd0);
            check("midrst_misalign", {31'd0, misalign}, 32'd0);
            check("midrst_stall", {31'd0, stall}, 32'd0);
            issue_valid = 1'b0;
            model_reset();
            a_v = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage and register scoreboard for the core. It merges ALU results and load responses onto the single `regfile` write port, and extracts and sign-extends load data. It tracks which architectural registers have writes in flight so decode can stall on RAW and WAW hazards. It sits between execute/LSU and `regfile`, and drives `w_addr_i`/`din_i` there.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32), datapath width.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `issue_valid_i` in 1: decode presents an instruction this cycle.
- `issue_rs1_i`, `issue_rs2_i`, `issue_rd_i` in 5 each: source and destination register indices of the issuing instruction.
- `stall_o` out 1: decode must hold the instruction; combinational.
- `alu_valid_i` in 1: ALU result valid.
- `alu_ready_o` out 1: ALU result accepted this cycle.
- `alu_rd_i` in 5: ALU destination register.
- `alu_data_i` in DATA_WIDTH: ALU result.
- `lsu_valid_i` in 1: load response valid; no backpressure is possible.
- `lsu_rd_i` in 5: load destination register.
- `lsu_funct3_i` in 3: load type. 000 = LB, 001 = LH, 010 = LW, 100 = LBU, 101 = LHU.
- `lsu_offset_i` in 2: byte address bits [1:0].
- `lsu_data_i` in DATA_WIDTH: raw aligned memory word.
- `w_addr_o` out 5: connects to `regfile` `w_addr_i`; 0 means no write.
- `din_o` out DATA_WIDTH: connects to `regfile` `din_i`.
- `misalign_o` out 1: one-cycle pulse, registered, for a misaligned load.

## Operation
- Scoreboard: 31-bit `busy` vector, one bit each for x1..x31. x0 is never busy.
- Stall rule: `stall_o = issue_valid_i & (busy[rs1] | busy[rs2] | busy[rd])`.
  - The `busy[rd]` term prevents WAW, because loads and ALU ops complete out of order.
- Set: on an edge where `issue_valid_i & ~stall_o & rd != 0`, `busy[rd]` is set.
- Clear: `busy[w_addr_o]` clears on the same edge at which `regfile` commits `w_addr_o`.
  - `busy` therefore stays set during the cycle the write is presented, because `regfile` reads have no bypass.
- Set and clear of the same index on the same edge: set wins.
- Arbitration: the load has priority. `alu_ready_o = ~lsu_valid_i`.
  - Accepted beat = load if `lsu_valid_i`, else ALU if `alu_valid_i`, else none.
- Load extraction:
  - Byte = `lsu_data_i[8*offset +: 8]`.
  - Halfword = `lsu_data_i[16*offset[1] +: 16]`.
  - LB/LH sign-extend to DATA_WIDTH; LBU/LHU zero-extend; LW passes the word through.
  - Other `funct3` values: treat as LW.
- Misalignment: LH/LHU with `offset[0] = 1`, or LW with `offset != 0`.
  - `misalign_o` pulses.
  - The write is still performed, with `offset[0]` (halfword) or `offset[1:0]` (word) forced to 0.
- A beat with rd = 0 is accepted and discarded: `w_addr_o` = 0 and no scoreboard change.

## Timing
- Reset values: `busy` = 0, `w_addr_o` = 0, `din_o` = 0, `misalign_o` = 0.
- `stall_o` and `alu_ready_o` are combinational from the inputs and `busy`. During reset, `stall_o` reflects the inputs only.
- Latency: a beat accepted at edge N drives `w_addr_o`/`din_o` during cycle N+1. `regfile` writes at edge N+1 and `busy` clears at edge N+1.
  - A dependent instruction is unstalled in cycle N+2 and reads the new value.
- `w_addr_o` returns to 0 in any cycle with no accepted beat. It is never held, which avoids repeated writes.
- ALU handshake: the ALU holds `alu_valid_i`/`alu_rd_i`/`alu_data_i` stable until `alu_ready_o`. An unaccepted beat is not registered.
- Reset asserted mid-operation: all state clears immediately. In-flight loads arriving after reset are written but find their `busy` bit already clear; this is harmless.

## Structure
- Load `funct3` encodings (`LB`, `LH`, `LW`, `LBU`, `LHU`) go in the shared `proc_define.sv`, next to `DATA_WIDTH`.
- Sub-module `load_extend`: combinational; inputs `funct3`, `offset`, `data`; outputs extended data and the misalign flag.
- Top level holds the arbitration, the output registers and the scoreboard.

## Test plan
- Reset, then ALU beat rd=5, data=0x1234. Required: `w_addr_o`=5, `din_o`=0x1234 in the next cycle only; `busy[5]` clear afterwards.
- Issue rd=3, then issue rs1=3. Required: `stall_o`=1 until the cycle after the x3 writeback, then 0; read of x3 returns the new value.
- Load and ALU valid together (lsu rd=4, alu rd=6). Required: `alu_ready_o`=0; x4 written first, x6 one cycle later.
- LB offset 2, data 0x00800000 → `din_o` 0xFFFFFF80. LBU same → 0x00000080. LHU offset 2, data 0xBEEF0000 → 0x0000BEEF.
- LW offset 1, data 0xDEADBEEF. Required: `misalign_o` pulses, `din_o`=0xDEADBEEF.
- Writeback of x7 and a new issue with rd=7 on the same edge. Required: `busy[7]` remains 1. ALU beat with rd=0: `w_addr_o` stays 0.
